axi4_lite_gpu_draw_engine: RTL and testbench
============================================

// Module: axi4_lite_gpu_draw_engine
// PURPOSE
// Register-mapped GPU command unit between the AXI4-Lite slave and the framebuffer BRAM write port.
// Supports single-pixel writes plus a hardware rectangle-fill engine that streams one pixel per clk.
// Fill rectangles are clipped to the frame. Raises a one-cycle done_irq when a fill completes.
// PARAMETERS
// FRAME_WIDTH_SCALED   640  pixels per row; also the row stride in the framebuffer
// FRAME_HEIGHT_SCALED  480  rows per frame
// AXI_ADDRESS_WIDTH    32   register address width (byte address; decode uses bits [4:2])
// AXI_DATA_WIDTH       32   register data width
// FBUF_ADDR_WIDTH      19   framebuffer address width; must hold W*H-1
// FBUF_DATA_WIDTH      8    pixel width; colour = data[FBUF_DATA_WIDTH-1:0]
// PORTS
// clk                     in   1    clock
// rst_n                   in   1    synchronous active-low reset
// read_processing_start   in   1    read request level from the AXI slave
// read_address            in   AXI_ADDRESS_WIDTH  register byte address
// read_data               out  AXI_DATA_WIDTH     read data
// read_processing_done    out  1    read complete
// read_resp_ok            out  1    1=OKAY, 0=SLVERR
// write_processing_start  in   1    write request level
// write_address           in   AXI_ADDRESS_WIDTH  register byte address
// write_data              in   AXI_DATA_WIDTH     write data
// write_processing_ok     out  1    1=OKAY, 0=SLVERR
// write_processing_done   out  1    write complete
// fbuf_en_wr, fbuf_wrea   out  1    BRAM enable / write enable (always driven equal)
// fbuf_addr               out  FBUF_ADDR_WIDTH    pixel address = x + y*FRAME_WIDTH_SCALED
// fbuf_data               out  FBUF_DATA_WIDTH    pixel colour
// busy                    out  1    fill engine active
// done_irq                out  1    one-cycle pulse on fill completion or abort
// BEHAVIOUR
// Reset: all outputs 0; registers 0; FSM=IDLE. Reset mid-fill aborts immediately with no irq.
// Handshake: done/ok are registered one cycle after start=1 and held while start=1. They clear the cycle after start drops.
// Each start=1 episode is one access; side effects happen once, on the first cycle.
// Register map (byte addr):
//  0x00 STATUS  RO  {27'b0, err, irq_seen, busy, rd_start, wr_start}; irq_seen is cleared on read
//  0x04 PIXEL   WO  x=[31:20], y=[19:8], colour=[7:0]; fbuf strobe 1 cycle after start
//  0x08 ORIGIN  RW  x0=[27:16], y0=[11:0]
//  0x0C SIZE    RW  w=[27:16], h=[11:0]
//  0x10 COLOR   RW  [FBUF_DATA_WIDTH-1:0]
//  0x14 CMD     WO  bit0=start fill, bit1=abort (abort wins if both are set)
//  0x18 COUNT   RO  pixels written by the current/last fill (zero-extended)
//  Any other address: read returns 32'hFFFFFFFF with resp_ok=0; write has no effect with ok=0.
// PIXEL write: rejected (ok=0, no strobe) if busy=1, x>=W, or y>=H.
// ORIGIN/SIZE/COLOR: writable while busy; values take effect at the next start.
// FSM: IDLE -> SETUP -> FILL -> IDLE.
//  CMD.start while busy: ok=0, ignored.
//  CMD.start with w==0, h==0, x0>=W, or y0>=H: err=1, ok=1, no fill, no irq.
//  SETUP (1 cycle): latch colour; x_end=min(x0+w,W)-1, y_end=min(y0+h,H)-1; row_base=y0*W; COUNT=0; err=0.
//  FILL: one pixel per cycle at row_base+x, raster order; x wraps to x0, row_base+=W.
//  FILL: after writing (x_end, y_end), pulse done_irq and return to IDLE.
//  CMD.abort in FILL: stop on the next cycle; the pixel in flight completes; done_irq pulses; err=0.
//  CMD.abort in IDLE: no effect, ok=1.
// busy=1 in SETUP and FILL. Fill latency = 2 + clipped_w*clipped_h cycles from CMD start to irq.
// Arithmetic: x/y are 12-bit unsigned; sums are computed 13-bit before clipping; address is truncated to FBUF_ADDR_WIDTH.
// A simultaneous read and write are serviced in parallel; STATUS reflects the pre-write state.
// TESTING
// Reset, then read 0x00 -> data 0, resp_ok=1; write 0x1C -> ok=0, done=1.
// PIXEL write 0x00A0_05_3C (x=10, y=5) -> fbuf addr 3210, data 0x3C, en/wrea high exactly 1 cycle.
// ORIGIN=(2,3), SIZE=(4,2), COLOR=0x7, CMD=1 -> 8 writes: addr 1922..1925, then 2562..2565; irq at cycle 10; COUNT=8.
// ORIGIN=(638,479), SIZE=(10,10) -> clipped to 2 pixels (addr 307198, 307199); irq pulses; err=0.
// Start 100x100 fill, then CMD=2 after 20 pixels -> <=21 writes, busy drops, irq pulses; PIXEL write during the fill -> ok=0.
// SIZE w=0 -> err=1, no fbuf activity; rst_n low mid-fill -> all outputs 0 the next cycle, no irq.

Source files
------------

// File: rtl/axi4_lite_gpu_draw_engine.sv
// Register-mapped GPU command unit: single-pixel writes and a clipped rectangle-fill
// engine streaming one pixel per clk into the framebuffer BRAM port.
module axi4_lite_gpu_draw_engine #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int AXI_ADDRESS_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH      = 32,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         read_processing_start,
  input  logic [AXI_ADDRESS_WIDTH-1:0] read_address,
  output logic [AXI_DATA_WIDTH-1:0]    read_data,
  output logic                         read_processing_done,
  output logic                         read_resp_ok,
  input  logic                         write_processing_start,
  input  logic [AXI_ADDRESS_WIDTH-1:0] write_address,
  input  logic [AXI_DATA_WIDTH-1:0]    write_data,
  output logic                         write_processing_ok,
  output logic                         write_processing_done,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data,
  output logic                         busy,
  output logic                         done_irq
);
  localparam logic [12:0] W13 = 13'(FRAME_WIDTH_SCALED);
  localparam logic [12:0] H13 = 13'(FRAME_HEIGHT_SCALED);
  localparam logic [FBUF_ADDR_WIDTH-1:0] STRIDE = FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);

  typedef enum logic [1:0] {IDLE, SETUP, FILL} state_t;
  state_t state, state_nx;

  logic                         rd_act, wr_act, err, irq_seen, irq_nx;
  logic [11:0]                  org_x, org_y, sz_w, sz_h;
  logic [11:0]                  cur_x, cur_y, x_start, x_end, y_end;
  logic [FBUF_DATA_WIDTH-1:0]   color_r, fill_color;
  logic [FBUF_ADDR_WIDTH-1:0]   row_base, pix_addr;
  logic [FBUF_ADDR_WIDTH:0]     count;
  logic [AXI_DATA_WIDTH-1:0]    rd_val;
  logic                         rd_ok_nx, wr_ok_nx;
  logic [12:0]                  x_sum, y_sum, x_lim, y_lim;
  logic unused_addr_bits;

  wire [2:0]  rd_sel    = read_address[4:2];
  wire [2:0]  wr_sel    = write_address[4:2];
  wire        rd_first  = read_processing_start & ~rd_act;
  wire        wr_first  = write_processing_start & ~wr_act;
  wire [11:0] px        = write_data[31:20];
  wire [11:0] py        = write_data[19:8];
  wire        start_bit = write_data[0] & ~write_data[1];
  wire        cmd_abort = wr_first && wr_sel == 3'd5 && write_data[1];
  wire        cmd_start = wr_first && wr_sel == 3'd5 && start_bit;
  wire        degenerate = sz_w == 12'd0 || sz_h == 12'd0 ||
                           {1'b0, org_x} >= W13 || {1'b0, org_y} >= H13;
  wire        pix_ok    = !busy && {1'b0, px} < W13 && {1'b0, py} < H13;
  wire        fill_last = cur_x == x_end && cur_y == y_end;

  assign busy      = state != IDLE;
  assign fbuf_wrea = fbuf_en_wr;
  assign pix_addr  = FBUF_ADDR_WIDTH'(32'(px) + 32'(py) * FRAME_WIDTH_SCALED);
  assign unused_addr_bits = ^{read_address[AXI_ADDRESS_WIDTH-1:5], read_address[1:0],
                              write_address[AXI_ADDRESS_WIDTH-1:5], write_address[1:0]};

  // Clip in 13 bits so x0+w cannot wrap before the min() against the frame.
  always_comb begin
    x_sum = {1'b0, org_x} + {1'b0, sz_w};
    y_sum = {1'b0, org_y} + {1'b0, sz_h};
    x_lim = (x_sum > W13) ? W13 : x_sum;
    y_lim = (y_sum > H13) ? H13 : y_sum;
  end

  always_comb begin
    rd_val   = '1;
    rd_ok_nx = 1'b1;
    case (rd_sel)
      3'd0: rd_val = AXI_DATA_WIDTH'({err, irq_seen, busy, rd_act, wr_act});
      3'd2: rd_val = AXI_DATA_WIDTH'({4'b0, org_x, 4'b0, org_y});
      3'd3: rd_val = AXI_DATA_WIDTH'({4'b0, sz_w, 4'b0, sz_h});
      3'd4: rd_val = AXI_DATA_WIDTH'(color_r);
      3'd6: rd_val = AXI_DATA_WIDTH'(count);
      3'd1, 3'd5: rd_val = '0;
      default: rd_ok_nx = 1'b0;
    endcase
  end

  always_comb begin
    wr_ok_nx = 1'b0;
    case (wr_sel)
      3'd1:             wr_ok_nx = pix_ok;
      3'd2, 3'd3, 3'd4: wr_ok_nx = 1'b1;
      3'd5:             wr_ok_nx = !(start_bit && busy);
      default:          wr_ok_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    irq_nx   = 1'b0;
    case (state)
      IDLE:  if (cmd_start && !degenerate) state_nx = SETUP;
      SETUP: if (cmd_abort) begin state_nx = IDLE; irq_nx = 1'b1; end
             else state_nx = FILL;
      FILL:  if (cmd_abort || fill_last) begin state_nx = IDLE; irq_nx = 1'b1; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_act <= 1'b0; wr_act <= 1'b0;
      read_data <= '0; read_processing_done <= 1'b0; read_resp_ok <= 1'b0;
      write_processing_ok <= 1'b0; write_processing_done <= 1'b0;
      fbuf_en_wr <= 1'b0; fbuf_addr <= '0; fbuf_data <= '0;
      done_irq <= 1'b0; irq_seen <= 1'b0; err <= 1'b0;
      org_x <= '0; org_y <= '0; sz_w <= '0; sz_h <= '0; color_r <= '0;
      fill_color <= '0; cur_x <= '0; cur_y <= '0; x_start <= '0;
      x_end <= '0; y_end <= '0; row_base <= '0; count <= '0;
    end else begin
      rd_act <= read_processing_start;
      wr_act <= write_processing_start;
      read_processing_done  <= read_processing_start;
      write_processing_done <= write_processing_start;
      if (!read_processing_start) begin read_data <= '0; read_resp_ok <= 1'b0; end
      else if (rd_first) begin read_data <= rd_val; read_resp_ok <= rd_ok_nx; end
      if (!write_processing_start) write_processing_ok <= 1'b0;
      else if (wr_first)           write_processing_ok <= wr_ok_nx;

      done_irq <= irq_nx;
      if (irq_nx) irq_seen <= 1'b1;
      else if (rd_first && rd_sel == 3'd0) irq_seen <= 1'b0;

      if (wr_first) begin
        case (wr_sel)
          3'd2: begin org_x <= write_data[27:16]; org_y <= write_data[11:0]; end
          3'd3: begin sz_w  <= write_data[27:16]; sz_h  <= write_data[11:0]; end
          3'd4: color_r <= write_data[FBUF_DATA_WIDTH-1:0];
          default: ;
        endcase
      end
      if (cmd_start && !busy && degenerate) err <= 1'b1;
      if (cmd_abort && busy) err <= 1'b0;

      fbuf_en_wr <= 1'b0;
      if (wr_first && wr_sel == 3'd1 && pix_ok) begin
        fbuf_en_wr <= 1'b1;
        fbuf_addr  <= pix_addr;
        fbuf_data  <= write_data[FBUF_DATA_WIDTH-1:0];
      end

      case (state)
        SETUP: begin
          fill_color <= color_r;
          cur_x <= org_x; cur_y <= org_y; x_start <= org_x;
          x_end <= 12'(x_lim - 13'd1);
          y_end <= 12'(y_lim - 13'd1);
          row_base <= FBUF_ADDR_WIDTH'(32'(org_y) * FRAME_WIDTH_SCALED);
          count <= '0;
          err   <= 1'b0;
        end
        FILL: begin
          // The pixel issued on the abort cycle still lands; the FSM exits afterwards.
          fbuf_en_wr <= 1'b1;
          fbuf_addr  <= row_base + FBUF_ADDR_WIDTH'(cur_x);
          fbuf_data  <= fill_color;
          count      <= count + 1'b1;
          if (cur_x == x_end) begin
            cur_x    <= x_start;
            cur_y    <= cur_y + 12'd1;
            row_base <= row_base + STRIDE;
          end else begin
            cur_x <= cur_x + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_gpu_draw_engine.sv
// Directed bench for the draw engine: register access, pixel writes, fills, clipping, abort, reset.
module tb_axi4_lite_gpu_draw_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_processing_start = 1'b0;
  logic [31:0] read_address = '0;
  logic [31:0] read_data;
  logic        read_processing_done, read_resp_ok;
  logic        write_processing_start = 1'b0;
  logic [31:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic        write_processing_ok, write_processing_done;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;
  logic        busy, done_irq;

  axi4_lite_gpu_draw_engine dut (
    .clk(clk), .rst_n(rst_n),
    .read_processing_start(read_processing_start), .read_address(read_address),
    .read_data(read_data), .read_processing_done(read_processing_done),
    .read_resp_ok(read_resp_ok),
    .write_processing_start(write_processing_start), .write_address(write_address),
    .write_data(write_data), .write_processing_ok(write_processing_ok),
    .write_processing_done(write_processing_done),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr),
    .fbuf_data(fbuf_data), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int irq_cyc = 0;
  logic [18:0] aq[$];
  logic [7:0]  dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && fbuf_en_wr) begin
      aq.push_back(fbuf_addr);
      dq.push_back(fbuf_data);
    end
    if (done_irq) begin
      irq_cnt <= irq_cnt + 1;
      irq_cyc <= cyc;
    end
  end

  // Sampled-at-cycle-1 results of the last access.
  logic [31:0] rd_data_s;
  logic rd_ok_s, rd_done_s, wr_ok_s, wr_done_s, fb_en_s, fb_we_s, busy_s;
  logic [18:0] fb_addr_s;
  logic [7:0]  fb_data_s;
  int c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    c0 = cyc;
    write_address = a; write_data = d; write_processing_start = 1'b1;
    step();
    wr_ok_s = write_processing_ok; wr_done_s = write_processing_done;
    fb_en_s = fbuf_en_wr; fb_we_s = fbuf_wrea; fb_addr_s = fbuf_addr;
    fb_data_s = fbuf_data; busy_s = busy;
    write_processing_start = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [31:0] a);
    read_address = a; read_processing_start = 1'b1;
    step();
    rd_data_s = read_data; rd_ok_s = read_resp_ok; rd_done_s = read_processing_done;
    read_processing_start = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (busy && n < lim) begin step(); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_pixels(input string tag, input int target, input int lim);
    int n = 0;
    while (aq.size() < target && n < lim) begin step(); n++; end
    chk(tag, 32'(aq.size() >= target), 32'd1);
  endtask

  function automatic logic any_out();
    return |{read_data, read_processing_done, read_resp_ok, write_processing_ok,
             write_processing_done, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data,
             busy, done_irq};
  endfunction

  initial begin
    int irq0;
    int exp5[8] = '{1922, 1923, 1924, 1925, 2562, 2563, 2564, 2565};

    repeat (3) step();
    chk("reset_outputs", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    step();

    do_read(32'h00);
    chk("status_reset_data", rd_data_s, 32'h0);
    chk("status_reset_ok", 32'(rd_ok_s), 32'd1);
    chk("status_reset_done", 32'(rd_done_s), 32'd1);
    do_read(32'h1C);
    chk("bad_read_data", rd_data_s, 32'hFFFF_FFFF);
    chk("bad_read_ok", 32'(rd_ok_s), 32'd0);
    do_write(32'h1C, 32'h1234);
    chk("bad_write_ok", 32'(wr_ok_s), 32'd0);
    chk("bad_write_done", 32'(wr_done_s), 32'd1);

    // Single pixel x=10 y=5 colour 0x3C
    aq.delete(); dq.delete();
    do_write(32'h04, 32'h00A0_053C);
    chk("pix_ok", 32'(wr_ok_s), 32'd1);
    chk("pix_en", 32'({fb_en_s, fb_we_s}), 32'd3);
    chk("pix_addr", 32'(fb_addr_s), 32'd3210);
    chk("pix_data", 32'(fb_data_s), 32'h3C);
    chk("pix_en_drop", 32'(fbuf_en_wr), 32'd0);
    chk("pix_done_drop", 32'(write_processing_done), 32'd0);
    chk("pix_count", 32'(aq.size()), 32'd1);
    do_write(32'h04, 32'h2800_0011);
    chk("pix_oob_ok", 32'(wr_ok_s), 32'd0);
    chk("pix_oob_en", 32'(fb_en_s), 32'd0);

    // 4x2 fill at (2,3)
    do_write(32'h08, 32'h0002_0003);
    do_write(32'h0C, 32'h0004_0002);
    do_write(32'h10, 32'h7);
    do_read(32'h08);
    chk("origin_rb", rd_data_s, 32'h0002_0003);
    aq.delete(); dq.delete(); irq0 = irq_cnt;
    do_write(32'h14, 32'h1);
    chk("fill_cmd_ok", 32'(wr_ok_s), 32'd1);
    chk("fill_busy", 32'(busy_s), 32'd1);
    wait_idle("fill_timeout", 50);
    chk("fill_npix", 32'(aq.size()), 32'd8);
    if (aq.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("fill_addr", 32'(aq[i]), 32'(exp5[i]));
        chk("fill_data", 32'(dq[i]), 32'h7);
      end
    chk("fill_irq_cnt", 32'(irq_cnt - irq0), 32'd1);
    chk("fill_irq_latency", 32'(irq_cyc - c0), 32'd10);
    do_read(32'h18);
    chk("fill_count", rd_data_s, 32'd8);
    do_read(32'h00);
    chk("status_irq_seen", rd_data_s, 32'h08);
    do_read(32'h00);
    chk("status_irq_clr", rd_data_s, 32'h00);

    // Clipped corner fill
    do_write(32'h08, 32'h027E_01DF);
    do_write(32'h0C, 32'h000A_000A);
    aq.delete(); dq.delete(); irq0 = irq_cnt;
    do_write(32'h14, 32'h1);
    wait_idle("clip_timeout", 50);
    chk("clip_npix", 32'(aq.size()), 32'd2);
    if (aq.size() == 2) begin
      chk("clip_addr0", 32'(aq[0]), 32'd307198);
      chk("clip_addr1", 32'(aq[1]), 32'd307199);
    end
    chk("clip_irq", 32'(irq_cnt - irq0), 32'd1);
    chk("clip_latency", 32'(irq_cyc - c0), 32'd4);
    do_read(32'h00);
    chk("clip_status", rd_data_s, 32'h08);

    // 100x100 fill aborted after 20 pixels, pixel write rejected while busy
    do_write(32'h08, 32'h0000_0000);
    do_write(32'h0C, 32'h0064_0064);
    aq.delete(); dq.delete(); irq0 = irq_cnt;
    do_write(32'h14, 32'h1);
    wait_pixels("abort_wait10", 10, 200);
    do_write(32'h04, 32'h00A0_053C);
    chk("busy_pix_ok", 32'(wr_ok_s), 32'd0);
    do_write(32'h14, 32'h1);
    chk("busy_start_ok", 32'(wr_ok_s), 32'd0);
    wait_pixels("abort_wait20", 20, 200);
    do_write(32'h14, 32'h2);
    chk("abort_ok", 32'(wr_ok_s), 32'd1);
    chk("abort_busy", 32'(busy_s), 32'd0);
    step();
    chk("abort_npix", 32'(aq.size() >= 20 && aq.size() <= 21), 32'd1);
    chk("abort_irq", 32'(irq_cnt - irq0), 32'd1);
    do_read(32'h18);
    chk("abort_count", rd_data_s, 32'(aq.size()));
    do_read(32'h00);
    chk("abort_status", rd_data_s, 32'h08);
    do_write(32'h14, 32'h2);
    chk("idle_abort_ok", 32'(wr_ok_s), 32'd1);

    // Zero-width fill
    do_write(32'h0C, 32'h0000_0005);
    aq.delete(); irq0 = irq_cnt;
    do_write(32'h14, 32'h1);
    chk("zero_ok", 32'(wr_ok_s), 32'd1);
    chk("zero_busy", 32'(busy_s), 32'd0);
    repeat (4) step();
    chk("zero_npix", 32'(aq.size()), 32'd0);
    chk("zero_irq", 32'(irq_cnt - irq0), 32'd0);
    do_read(32'h00);
    chk("zero_status_err", rd_data_s, 32'h10);

    // Reset in the middle of a fill
    do_write(32'h0C, 32'h0064_0064);
    do_write(32'h14, 32'h1);
    repeat (5) step();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    irq0 = irq_cnt;
    rst_n = 1'b0;
    step();
    chk("rst_mid_outputs", 32'(any_out()), 32'd0);
    repeat (3) step();
    chk("rst_mid_irq", 32'(irq_cnt - irq0), 32'd0);
    rst_n = 1'b1;
    step();
    do_read(32'h00);
    chk("rst_status", rd_data_s, 32'h0);
    do_read(32'h0C);
    chk("rst_size", rd_data_s, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
